ifmap_window_sequencer: RTL and testbench

Clocked read sequencer directly downstream of the ifmap memory's completion output. It accepts the convolution output size once all ifmap data is stored, then walks every window origin (y, x) for both timesteps. For each origin it issues a 13-bit read address to the memory read-request channel and pairs the returned window with its coordinates. It forwards tagged windows in order to the PE dispatch stage.

---
 rtl/ifmap_window_sequencer_if.sv | 40 ++++
 rtl/ifmap_window_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_ifmap_window_sequencer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifmap_window_sequencer_if.sv
`default_nettype none
// ============================================================================
// ifmap_window_sequencer_if : cfg / read-request / response / window channels
// Rev 1.0
// ============================================================================
interface ifmap_window_sequencer_if #(
  parameter int WIN_W = 25
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [5:0]       cfg_size;
  logic             req_valid;
  logic             req_ready;
  logic [12:0]      req_addr;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIN_W-1:0] rsp_window;
  logic             win_valid;
  logic             win_ready;
  logic [WIN_W-1:0] win_data;
  logic [5:0]       win_y;
  logic [5:0]       win_x;
  logic             win_ts;
  logic             win_last;
  logic             done;
  logic             cfg_err;

  modport master (
    input  cfg_valid, cfg_size, req_ready, rsp_valid, rsp_window, win_ready,
    output cfg_ready, req_valid, req_addr, rsp_ready,
           win_valid, win_data, win_y, win_x, win_ts, win_last, done, cfg_err
  );

  modport slave (
    output cfg_valid, cfg_size, req_ready, rsp_valid, rsp_window, win_ready,
    input  cfg_ready, req_valid, req_addr, rsp_ready,
           win_valid, win_data, win_y, win_x, win_ts, win_last, done, cfg_err
  );
endinterface
`default_nettype wire

// File: rtl/ifmap_window_sequencer.sv
`default_nettype none
// ============================================================================
// ifmap_window_sequencer : walks (y, x, ts) origins, issues reads, tags windows
// Rev 1.0
// ============================================================================
module ifmap_window_sequencer #(
  parameter int WIN_W   = 25,
  parameter int MAX_DIM = 36,
  parameter int MAX_OUT = 4
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  ifmap_window_sequencer_if.master  bus
);

  localparam int         C_PW      = $clog2(MAX_OUT);
  localparam int         C_CW      = C_PW + 1;
  localparam logic [5:0] C_MAX_DIM = 6'(MAX_DIM);

  localparam logic [1:0] C_IDLE  = 2'd0;
  localparam logic [1:0] C_ISSUE = 2'd1;
  localparam logic [1:0] C_DRAIN = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [5:0]       size_q, size_d;
  logic [5:0]       y_q, y_d;
  logic [5:0]       x_q, x_d;
  logic             ts_q, ts_d;
  logic [C_PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [C_PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [C_CW-1:0]  count_q, count_d;
  logic [13:0]      tag_mem_q [MAX_OUT];
  logic [13:0]      tag_mem_d [MAX_OUT];
  logic             win_valid_q, win_valid_d;
  logic [WIN_W-1:0] win_data_q, win_data_d;
  logic [5:0]       win_y_q, win_y_d;
  logic [5:0]       win_x_q, win_x_d;
  logic             win_ts_q, win_ts_d;
  logic             win_last_q, win_last_d;
  logic             done_q, done_d;
  logic             cfg_err_q, cfg_err_d;

  logic       cfg_ready;
  logic       req_valid;
  logic       rsp_ready;
  logic       fifo_full;
  logic       fifo_empty;
  logic       cfg_fire;
  logic       cfg_bad;
  logic       push;
  logic       pop;
  logic       win_fire;
  logic       last_origin;
  logic [5:0] size_m1;
  logic [13:0] rd_tag;

  assign fifo_full   = (count_q == C_CW'(MAX_OUT));
  assign fifo_empty  = (count_q == '0);
  assign size_m1     = size_q - 6'd1;
  assign last_origin = (y_q == size_m1) && (x_q == size_m1) && ts_q;
  assign cfg_fire    = bus.cfg_valid && cfg_ready;
  assign cfg_bad     = (bus.cfg_size == 6'd0) || (bus.cfg_size > C_MAX_DIM);
  assign push        = req_valid && bus.req_ready;
  assign pop         = bus.rsp_valid && rsp_ready;
  assign win_fire    = win_valid_q && bus.win_ready;
  assign rd_tag      = tag_mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= C_IDLE;
      size_q      <= '0;
      y_q         <= '0;
      x_q         <= '0;
      ts_q        <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tag_mem_q   <= '{default: '0};
      win_valid_q <= 1'b0;
      win_data_q  <= '0;
      win_y_q     <= '0;
      win_x_q     <= '0;
      win_ts_q    <= 1'b0;
      win_last_q  <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      y_q         <= y_d;
      x_q         <= x_d;
      ts_q        <= ts_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      tag_mem_q   <= tag_mem_d;
      win_valid_q <= win_valid_d;
      win_data_q  <= win_data_d;
      win_y_q     <= win_y_d;
      win_x_q     <= win_x_d;
      win_ts_q    <= win_ts_d;
      win_last_q  <= win_last_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // Next-state: the final window leaving the output register retires the map.
  always_comb begin
    state_d = state_q;
    case (state_q)
      C_IDLE:  if (cfg_fire && !cfg_bad) state_d = C_ISSUE;
      C_ISSUE: if (push && last_origin) state_d = C_DRAIN;
      C_DRAIN: if (win_fire && win_last_q && fifo_empty) state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (state_q == C_IDLE);
    req_valid = (state_q == C_ISSUE) && !fifo_full;
    rsp_ready = !fifo_empty && (!win_valid_q || bus.win_ready);
  end

  always_comb begin
    size_d    = size_q;
    y_d       = y_q;
    x_d       = x_q;
    ts_d      = ts_q;
    cfg_err_d = 1'b0;
    done_d    = (state_q == C_DRAIN) && win_fire && win_last_q && fifo_empty;

    if (cfg_fire) begin
      if (cfg_bad) begin
        cfg_err_d = 1'b1;
      end else begin
        size_d = bus.cfg_size;
        y_d    = '0;
        x_d    = '0;
        ts_d   = 1'b0;
      end
    end else if (push) begin
      ts_d = ~ts_q;
      if (ts_q) begin
        if (x_q == size_m1) begin
          x_d = '0;
          y_d = (y_q == size_m1) ? 6'd0 : y_q + 6'd1;
        end else begin
          x_d = x_q + 6'd1;
        end
      end
    end

    tag_mem_d = tag_mem_q;
    if (push) tag_mem_d[wr_ptr_q] = {y_q, x_q, ts_q, last_origin};
    wr_ptr_d = wr_ptr_q + C_PW'(push);
    rd_ptr_d = rd_ptr_q + C_PW'(pop);
    count_d  = count_q + C_CW'(push) - C_CW'(pop);

    win_valid_d = win_valid_q;
    win_data_d  = win_data_q;
    win_y_d     = win_y_q;
    win_x_d     = win_x_q;
    win_ts_d    = win_ts_q;
    win_last_d  = win_last_q;
    if (pop) begin
      win_valid_d = 1'b1;
      win_data_d  = bus.rsp_window;
      win_y_d     = rd_tag[13:8];
      win_x_d     = rd_tag[7:2];
      win_ts_d    = rd_tag[1];
      win_last_d  = rd_tag[0];
    end else if (win_fire) begin
      win_valid_d = 1'b0;
      win_last_d  = 1'b0;
    end
  end

  assign bus.cfg_ready = cfg_ready;
  assign bus.req_valid = req_valid;
  assign bus.req_addr  = {y_q, x_q, ts_q};
  assign bus.rsp_ready = rsp_ready;
  assign bus.win_valid = win_valid_q;
  assign bus.win_data  = win_data_q;
  assign bus.win_y     = win_y_q;
  assign bus.win_x     = win_x_q;
  assign bus.win_ts    = win_ts_q;
  assign bus.win_last  = win_last_q;
  assign bus.done      = done_q;
  assign bus.cfg_err   = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ifmap_window_sequencer.sv
`default_nettype none
// ============================================================================
// tb_ifmap_window_sequencer : directed bench with a latency-2 memory model
// Rev 1.0
// ============================================================================
module tb_ifmap_window_sequencer;

  logic clk;
  logic rst;

  ifmap_window_sequencer_if #(.WIN_W(25)) bus ();

  ifmap_window_sequencer #(.WIN_W(25), .MAX_DIM(36), .MAX_OUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int cyc, n_req, n_win, n_done, n_err, req_idx, win_idx, cur_size, last_cyc, mem_allow;
  logic        rst_drv, cfg_valid_drv, req_ready_drv, win_ready_drv;
  logic [5:0]  cfg_size_drv;
  bit          req_rand, win_rand;
  logic [12:0] mem_addr_q [$];
  int          mem_t_q [$];
  logic [13:0] last_tag;
  logic [24:0] held_data;
  logic [12:0] held_tag;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] exp_addr(input int i, input int s);
    int y, x, t;
    if (s < 1) return 13'h1fff;
    t = i % 2;
    x = (i / 2) % s;
    y = i / (2 * s);
    return {6'(y), 6'(x), 1'(t)};
  endfunction

  function automatic logic [24:0] mem_word(input logic [12:0] a);
    return {a, a[11:0]};
  endfunction

  // One cycle: drive at negedge, observe 1ns later, account for the upcoming edge.
  task automatic step();
    logic [12:0] e;
    logic        l;
    @(negedge clk);
    cyc++;
    rst           = rst_drv;
    bus.cfg_valid = cfg_valid_drv;
    bus.cfg_size  = cfg_size_drv;
    bus.req_ready = req_rand ? ($urandom_range(0, 1) == 1) : req_ready_drv;
    bus.win_ready = win_rand ? ($urandom_range(0, 1) == 1) : win_ready_drv;
    if (mem_addr_q.size() > 0 && mem_allow != 0 && mem_t_q[0] <= cyc) begin
      bus.rsp_valid  = 1'b1;
      bus.rsp_window = mem_word(mem_addr_q[0]);
    end else begin
      bus.rsp_valid  = 1'b0;
      bus.rsp_window = '0;
    end
    #1;
    if (!rst_drv) begin
      if (bus.req_valid && bus.req_ready) begin
        check("req_addr", 64'(bus.req_addr), 64'(exp_addr(req_idx, cur_size)));
        req_idx++;
        n_req++;
        mem_addr_q.push_back(bus.req_addr);
        mem_t_q.push_back(cyc + 2);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        void'(mem_addr_q.pop_front());
        void'(mem_t_q.pop_front());
        if (mem_allow > 0) mem_allow--;
      end
      if (bus.win_valid && bus.win_ready) begin
        e = exp_addr(win_idx, cur_size);
        l = (win_idx == 2 * cur_size * cur_size - 1);
        check("window", 64'({bus.win_data, bus.win_y, bus.win_x, bus.win_ts, bus.win_last}),
              64'({mem_word(e), e, l}));
        last_tag = {bus.win_y, bus.win_x, bus.win_ts, bus.win_last};
        win_idx++;
        n_win++;
        if (bus.win_last) last_cyc = cyc;
      end
      if (bus.done) begin
        n_done++;
        check("done_timing", 64'(cyc), 64'(last_cyc + 1));
        check("cfg_ready_at_done", 64'(bus.cfg_ready), 64'd1);
      end
      if (bus.cfg_err) n_err++;
    end
  endtask

  task automatic reset_model(input int size);
    req_idx  = 0;
    win_idx  = 0;
    n_req    = 0;
    n_win    = 0;
    n_done   = 0;
    cur_size = size;
    last_cyc = -10;
    mem_addr_q.delete();
    mem_t_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, 64'({bus.cfg_ready, bus.req_valid, bus.rsp_ready, bus.win_valid,
                               bus.win_last, bus.done, bus.cfg_err}), 64'b1000000);
    check({tag, "_data"}, 64'({bus.win_data, bus.win_y, bus.win_x, bus.win_ts, bus.req_addr}), 64'd0);
  endtask

  task automatic apply_reset();
    rst_drv = 1'b1;
    step();
    rst_drv = 1'b0;
    step();
  endtask

  task automatic send_cfg(input logic [5:0] size);
    cfg_valid_drv = 1'b1;
    cfg_size_drv  = size;
    step();
    check("cfg_ready_on_cfg", 64'(bus.cfg_ready), 64'd1);
    cfg_valid_drv = 1'b0;
  endtask

  task automatic run_until_done(input int budget);
    int d0;
    d0 = n_done;
    for (int i = 0; i < budget && n_done == d0; i++) step();
    check("done_seen", 64'(n_done - d0), 64'd1);
  endtask

  initial begin
    cyc = 0; n_err = 0; mem_allow = -1;
    rst_drv = 1'b1; cfg_valid_drv = 1'b0; cfg_size_drv = '0;
    req_ready_drv = 1'b1; win_ready_drv = 1'b1; req_rand = 0; win_rand = 0;
    rst = 1'b1;
    bus.cfg_valid = 1'b0; bus.cfg_size = '0; bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0; bus.rsp_window = '0; bus.win_ready = 1'b0;
    reset_model(0);
    repeat (3) step();
    rst_drv = 1'b0;
    step();
    check_reset_outputs("reset");

    // size 2, always-ready consumer
    reset_model(2);
    send_cfg(6'd2);
    step();
    check("req_valid_first", 64'(bus.req_valid), 64'd1);
    run_until_done(200);
    check("t1_reqs", 64'(n_req), 64'd8);
    check("t1_wins", 64'(n_win), 64'd8);
    repeat (5) step();
    check("t1_done_once", 64'(n_done), 64'd1);

    // out-of-range sizes
    reset_model(0);
    n_err = 0;
    send_cfg(6'd0);
    step();
    check("err_size0", 64'(bus.cfg_err), 64'd1);
    check("err_size0_ready", 64'(bus.cfg_ready), 64'd1);
    step();
    check("err_pulse_width", 64'(bus.cfg_err), 64'd0);
    send_cfg(6'd37);
    step();
    check("err_size37", 64'(bus.cfg_err), 64'd1);
    step();
    check("err_no_req", 64'(bus.req_valid), 64'd0);
    check("err_ready", 64'(bus.cfg_ready), 64'd1);
    check("err_count", 64'(n_err), 64'd2);
    check("err_req_count", 64'(n_req), 64'd0);

    // outstanding cap with withheld responses
    reset_model(3);
    mem_allow = 0;
    send_cfg(6'd3);
    repeat (15) step();
    check("cap_reqs", 64'(n_req), 64'd4);
    check("cap_req_valid", 64'(bus.req_valid), 64'd0);
    mem_allow = 1;
    repeat (10) step();
    check("cap_reqs_after_one", 64'(n_req), 64'd5);
    check("cap_req_valid_after", 64'(bus.req_valid), 64'd0);
    check("cap_wins", 64'(n_win), 64'd1);
    apply_reset();
    check_reset_outputs("cap_reset");

    // consumer stall with size 1
    reset_model(1);
    mem_allow = -1;
    win_ready_drv = 1'b0;
    send_cfg(6'd1);
    for (int i = 0; i < 20 && !bus.win_valid; i++) step();
    check("stall_win_valid", 64'(bus.win_valid), 64'd1);
    held_data = bus.win_data;
    held_tag  = {bus.win_y, bus.win_x, bus.win_ts};
    check("stall_first_tag", 64'({held_data, held_tag}), 64'({mem_word(13'h000), 13'h000}));
    repeat (10) begin
      step();
      check("stall_rsp_ready", 64'(bus.rsp_ready), 64'd0);
      check("stall_hold", 64'({bus.win_valid, bus.win_data, bus.win_y, bus.win_x, bus.win_ts}),
            64'({1'b1, held_data, held_tag}));
    end
    win_ready_drv = 1'b1;
    run_until_done(50);
    check("stall_wins", 64'(n_win), 64'd2);

    // reset with three tags outstanding
    reset_model(3);
    mem_allow = 0;
    send_cfg(6'd3);
    for (int i = 0; i < 20 && n_req < 3; i++) step();
    check("midrst_reqs", 64'(n_req), 64'd3);
    rst_drv = 1'b1;
    req_ready_drv = 1'b0;
    win_ready_drv = 1'b0;
    step();
    rst_drv = 1'b0;
    mem_allow = -1;
    step();
    check_reset_outputs("midrst");
    req_ready_drv = 1'b1;
    win_ready_drv = 1'b1;
    reset_model(2);
    send_cfg(6'd2);
    step();
    check("midrst_restart_addr", 64'({bus.req_valid, bus.req_addr}), 64'({1'b1, 13'h000}));
    run_until_done(200);
    check("midrst_wins", 64'(n_win), 64'd8);

    // full-size map with random backpressure
    reset_model(36);
    req_rand = 1;
    win_rand = 1;
    send_cfg(6'd36);
    run_until_done(40000);
    check("big_reqs", 64'(n_req), 64'd2592);
    check("big_wins", 64'(n_win), 64'd2592);
    check("big_final", 64'(last_tag), 64'({6'd35, 6'd35, 1'b1, 1'b1}));
    req_rand = 0;
    win_rand = 0;
    repeat (5) step();
    check("big_no_extra", 64'(n_win), 64'd2592);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
